// File: rtl/draw_pkg.sv
// Shared definitions for the DrawUnit command interface: opcodes, packet sizes,
// default screen bounds and header field positions.
package draw_pkg;

   localparam logic [3:0] OP_FILL_RECT = 4'h1;
   localparam logic [3:0] OP_PIXEL     = 4'h2;

   localparam int unsigned FILL_WORDS  = 5;
   localparam int unsigned PIXEL_WORDS = 3;

   localparam int unsigned X_MAX_DEF = 639;
   localparam int unsigned Y_MAX_DEF = 479;

   localparam int unsigned HDR_OP_LSB    = 12;
   localparam int unsigned HDR_COLOR_LSB = 9;

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StDone
   } wr_state_e;

   function automatic logic is_legal_op(logic [3:0] op);
      return (op == OP_FILL_RECT) || (op == OP_PIXEL);
   endfunction

endpackage

// File: rtl/draw_coord_norm.sv
// Clamps a coordinate pair to [0, CMAX] and orders it; a_clamp_o keeps the
// first coordinate for single-point commands.
module draw_coord_norm #(
   parameter int unsigned CMAX = 639,
   parameter int unsigned CW   = 10
) (
   input  logic [CW-1:0] a_i,
   input  logic [CW-1:0] b_i,
   output logic [CW-1:0] a_clamp_o,
   output logic [CW-1:0] lo_o,
   output logic [CW-1:0] hi_o
);

   localparam logic [CW-1:0] MaxC = CW'(CMAX);

   logic [CW-1:0] b_clamp;

   always_comb begin
      a_clamp_o = (a_i > MaxC) ? MaxC : a_i;
      b_clamp   = (b_i > MaxC) ? MaxC : b_i;
      if (a_clamp_o <= b_clamp) begin
         lo_o = a_clamp_o;
         hi_o = b_clamp;
      end else begin
         lo_o = b_clamp;
         hi_o = a_clamp_o;
      end
   end

endmodule

// File: rtl/draw_cmd_writer.sv
// Producer side of the DrawUnit command FIFO: latches one normalised request and
// streams it as header + coordinate words, stalling on the FIFO full flag.
module draw_cmd_writer
   import draw_pkg::*;
#(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned COLOR_W = 3,
   parameter int unsigned X_MAX   = X_MAX_DEF,
   parameter int unsigned Y_MAX   = Y_MAX_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [3:0]         req_op,
   input  logic [COLOR_W-1:0] req_color,
   input  logic [9:0]         req_x0,
   input  logic [9:0]         req_x1,
   input  logic [9:0]         req_y0,
   input  logic [9:0]         req_y1,
   input  logic               full,
   output logic               we,
   output logic [DATA_W-1:0]  data,
   output logic               busy,
   output logic               done,
   output logic               err
);

   wr_state_e state_q, state_d;
   logic [2:0]         idx_q, idx_d;
   logic [3:0]         op_q, op_d;
   logic [COLOR_W-1:0] color_q, color_d;
   logic [9:0]         xl_q, xl_d, xr_q, xr_d;
   logic [9:0]         yt_q, yt_d, yb_q, yb_d;
   logic               err_q, err_d;

   logic [9:0]        x_a, x_lo, x_hi, y_a, y_lo, y_hi;
   logic [2:0]        last_idx;
   logic [DATA_W-1:0] word;

   draw_coord_norm #(.CMAX(X_MAX), .CW(10)) u_norm_x (
      .a_i      (req_x0),
      .b_i      (req_x1),
      .a_clamp_o(x_a),
      .lo_o     (x_lo),
      .hi_o     (x_hi)
   );

   draw_coord_norm #(.CMAX(Y_MAX), .CW(10)) u_norm_y (
      .a_i      (req_y0),
      .b_i      (req_y1),
      .a_clamp_o(y_a),
      .lo_o     (y_lo),
      .hi_o     (y_hi)
   );

   assign last_idx = (op_q == OP_FILL_RECT) ? 3'(FILL_WORDS - 1) : 3'(PIXEL_WORDS - 1);
   assign err      = err_q;

   // PIXEL reuses the xl/yt slots, so words 1 and 2 are the same for both ops.
   always_comb begin
      word = '0;
      unique case (idx_q)
         3'd0: begin
            word[HDR_OP_LSB +: 4]          = op_q;
            word[HDR_COLOR_LSB +: COLOR_W] = color_q;
         end
         3'd1:    word = DATA_W'(xl_q);
         3'd2:    word = DATA_W'(yt_q);
         3'd3:    word = DATA_W'(xr_q);
         3'd4:    word = DATA_W'(yb_q);
         default: word = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      op_d      = op_q;
      color_d   = color_q;
      xl_d      = xl_q;
      xr_d      = xr_q;
      yt_d      = yt_q;
      yb_d      = yb_q;
      err_d     = 1'b0;
      req_ready = 1'b0;
      we        = 1'b0;
      data      = '0;
      busy      = 1'b0;
      done      = 1'b0;

      unique case (state_q)
         StIdle: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (is_legal_op(req_op)) begin
                  op_d    = req_op;
                  color_d = req_color;
                  xl_d    = (req_op == OP_PIXEL) ? x_a : x_lo;
                  yt_d    = (req_op == OP_PIXEL) ? y_a : y_lo;
                  xr_d    = x_hi;
                  yb_d    = y_hi;
                  idx_d   = '0;
                  state_d = StSend;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StSend: begin
            busy = 1'b1;
            data = word;
            we   = !full;
            if (we) begin
               if (idx_q == last_idx) begin
                  state_d = StDone;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         StDone: begin
            done    = 1'b1;
            idx_d   = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         idx_q   <= '0;
         op_q    <= '0;
         color_q <= '0;
         xl_q    <= '0;
         xr_q    <= '0;
         yt_q    <= '0;
         yb_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         op_q    <= op_d;
         color_q <= color_d;
         xl_q    <= xl_d;
         xr_q    <= xr_d;
         yt_q    <= yt_d;
         yb_q    <= yb_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_draw_cmd_writer.sv
// Directed and scoreboarded bench for draw_cmd_writer; inputs change and outputs
// are sampled around the falling clock edge.
module tb_draw_cmd_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [2:0]  req_color;
   logic [9:0]  req_x0, req_x1, req_y0, req_y1;
   logic        full;
   logic        we;
   logic [15:0] data;
   logic        busy, done, err;

   int checks = 0;
   int errors = 0;

   draw_cmd_writer dut (
      .clk      (clk),
      .reset    (reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_op   (req_op),
      .req_color(req_color),
      .req_x0   (req_x0),
      .req_x1   (req_x1),
      .req_y0   (req_y0),
      .req_y1   (req_y1),
      .full     (full),
      .we       (we),
      .data     (data),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1);
   end

   // Drive a request for one edge, then scramble the fields to prove they are latched.
   task automatic send_req(input logic [3:0] op, input logic [2:0] c,
                           input logic [9:0] x0, input logic [9:0] y0,
                           input logic [9:0] x1, input logic [9:0] y1);
      req_valid = 1'b1;
      req_op    = op;
      req_color = c;
      req_x0    = x0;
      req_y0    = y0;
      req_x1    = x1;
      req_y1    = y1;
      @(negedge clk);
      req_valid = 1'b0;
      req_op    = 4'hF;
      req_color = 3'b111;
      req_x0    = 10'h3FF;
      req_y0    = 10'h155;
      req_x1    = 10'h2AA;
      req_y1    = 10'h0F0;
      #1;
   endtask

   function automatic logic [9:0] clampv(logic [9:0] v, logic [9:0] m);
      return (v > m) ? m : v;
   endfunction

   task automatic test_reset();
      reset     = 1'b1;
      req_valid = 1'b1;
      req_op    = 4'h1;
      req_color = 3'b101;
      req_x0    = 10'd1;
      req_y0    = 10'd2;
      req_x1    = 10'd3;
      req_y1    = 10'd4;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if ({req_ready, we, busy, done, err} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy/we/busy/done/err=%b want 10000",
                     {req_ready, we, busy, done, err});
         end
         checks++;
         if (data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data: got %h want 0000", data);
         end
      end
      reset     = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if ({req_ready, we, busy} !== 3'b100) begin
         errors++;
         $display("FAIL reset_wins: got rdy/we/busy=%b want 100", {req_ready, we, busy});
      end
   endtask

   task automatic test_fill_basic();
      logic [15:0] exp_w [5];
      exp_w = '{16'h1A00, 16'h000A, 16'h0014, 16'h0064, 16'h0032};
      send_req(4'h1, 3'b101, 10'd10, 10'd20, 10'd100, 10'd50);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({we, busy, req_ready} !== 3'b110 || data !== exp_w[i]) begin
            errors++;
            $display("FAIL fill_word%0d: got we/busy/rdy=%b data=%h want 110 data=%h",
                     i, {we, busy, req_ready}, data, exp_w[i]);
         end
         @(negedge clk);
         #1;
      end
      checks++;
      if ({done, busy, we, req_ready} !== 4'b1000 || data !== 16'h0000) begin
         errors++;
         $display("FAIL fill_done: got done/busy/we/rdy=%b data=%h want 1000 data=0000",
                  {done, busy, we, req_ready}, data);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({done, req_ready} !== 2'b01) begin
         errors++;
         $display("FAIL fill_idle: got done/rdy=%b want 01", {done, req_ready});
      end
   endtask

   task automatic test_fill_clamp();
      logic [15:0] exp_w [5];
      exp_w = '{16'h1600, 16'h0005, 16'h01DF, 16'h027F, 16'h01DF};
      send_req(4'h1, 3'b011, 10'd700, 10'd600, 10'd5, 10'd479);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (we !== 1'b1 || data !== exp_w[i]) begin
            errors++;
            $display("FAIL clamp_word%0d: got we=%b data=%h want we=1 data=%h",
                     i, we, data, exp_w[i]);
         end
         @(negedge clk);
         #1;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL clamp_done: got done=%b want 1", done);
      end
      @(negedge clk);
      #1;
   endtask

   task automatic test_pixel_stall();
      logic        pat   [6];
      logic        exp_we[6];
      logic [15:0] exp_d [6];
      int          pulses;
      pat    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      exp_we = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      exp_d  = '{16'h2400, 16'h027F, 16'h027F, 16'h027F, 16'h027F, 16'h0000};
      pulses = 0;
      send_req(4'h2, 3'b010, 10'd639, 10'd0, 10'd5, 10'd7);
      for (int k = 0; k < 6; k++) begin
         full = pat[k];
         #1;
         if (we === 1'b1) pulses++;
         checks++;
         if (we !== exp_we[k] || data !== exp_d[k] || busy !== 1'b1) begin
            errors++;
            $display("FAIL pixel_cyc%0d: got we=%b busy=%b data=%h want we=%b busy=1 data=%h",
                     k, we, busy, data, exp_we[k], exp_d[k]);
         end
         @(negedge clk);
      end
      full = 1'b0;
      #1;
      checks++;
      if (pulses != 3) begin
         errors++;
         $display("FAIL pixel_pulses: got %0d want 3", pulses);
      end
      checks++;
      if ({done, busy, we} !== 3'b100) begin
         errors++;
         $display("FAIL pixel_done: got done/busy/we=%b want 100", {done, busy, we});
      end
      @(negedge clk);
      #1;
   endtask

   task automatic test_illegal_op();
      req_valid = 1'b1;
      req_op    = 4'h7;
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      checks++;
      if ({err, we, busy, req_ready} !== 4'b1001) begin
         errors++;
         $display("FAIL illegal_err: got err/we/busy/rdy=%b want 1001",
                  {err, we, busy, req_ready});
      end
      @(negedge clk);
      #1;
      checks++;
      if ({err, we, busy, req_ready} !== 4'b0001) begin
         errors++;
         $display("FAIL illegal_after: got err/we/busy/rdy=%b want 0001",
                  {err, we, busy, req_ready});
      end
   endtask

   task automatic test_reset_mid();
      send_req(4'h1, 3'b101, 10'd10, 10'd20, 10'd100, 10'd50);
      repeat (2) begin
         @(negedge clk);
         #1;
      end
      checks++;
      if (we !== 1'b1 || data !== 16'h0014) begin
         errors++;
         $display("FAIL midrst_word2: got we=%b data=%h want we=1 data=0014", we, data);
      end
      reset = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if ({we, busy, req_ready} !== 3'b001 || data !== 16'h0000) begin
         errors++;
         $display("FAIL midrst_abort: got we/busy/rdy=%b data=%h want 001 data=0000",
                  {we, busy, req_ready}, data);
      end
      reset = 1'b0;
      send_req(4'h2, 3'b010, 10'd639, 10'd0, 10'd0, 10'd0);
      checks++;
      if (we !== 1'b1 || data !== 16'h2400) begin
         errors++;
         $display("FAIL midrst_fresh: got we=%b data=%h want we=1 data=2400", we, data);
      end
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL midrst_idle: got rdy=%b want 1", req_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_w [5];
      logic [3:0]  op;
      logic [2:0]  c;
      logic [9:0]  x0, x1, y0, y1, cx0, cx1, cy0, cy1;
      int          nexp, got;
      logic        finished;
      for (int r = 0; r < 100; r++) begin
         op  = ($urandom_range(1) == 0) ? 4'h1 : 4'h2;
         c   = 3'($urandom);
         x0  = 10'($urandom);
         x1  = 10'($urandom);
         y0  = 10'($urandom);
         y1  = 10'($urandom);
         cx0 = clampv(x0, 10'd639);
         cx1 = clampv(x1, 10'd639);
         cy0 = clampv(y0, 10'd479);
         cy1 = clampv(y1, 10'd479);
         exp_w[0] = {op, c, 9'b0};
         if (op == 4'h1) begin
            nexp     = 5;
            exp_w[1] = {6'b0, (cx0 < cx1) ? cx0 : cx1};
            exp_w[2] = {6'b0, (cy0 < cy1) ? cy0 : cy1};
            exp_w[3] = {6'b0, (cx0 < cx1) ? cx1 : cx0};
            exp_w[4] = {6'b0, (cy0 < cy1) ? cy1 : cy0};
         end else begin
            nexp     = 3;
            exp_w[1] = {6'b0, cx0};
            exp_w[2] = {6'b0, cy0};
            exp_w[3] = 16'h0;
            exp_w[4] = 16'h0;
         end
         req_valid = 1'b1;
         req_op    = op;
         req_color = c;
         req_x0    = x0;
         req_x1    = x1;
         req_y0    = y0;
         req_y1    = y1;
         @(negedge clk);
         req_valid = 1'b0;
         got       = 0;
         finished  = 1'b0;
         for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            full = 1'($urandom_range(1));
            #1;
            checks++;
            if (we !== (busy & ~full)) begin
               errors++;
               $display("FAIL b2b_we req%0d: got we=%b with busy=%b full=%b", r, we, busy, full);
            end
            if (we === 1'b1) begin
               checks++;
               if (got >= nexp) begin
                  errors++;
                  $display("FAIL b2b_extra req%0d: got word %0d data=%h want only %0d words",
                           r, got, data, nexp);
               end else if (data !== exp_w[got]) begin
                  errors++;
                  $display("FAIL b2b_data req%0d word%0d: got %h want %h",
                           r, got, data, exp_w[got]);
               end
               got++;
            end
            if (done === 1'b1) finished = 1'b1;
            else @(negedge clk);
         end
         checks++;
         if (!finished || got != nexp) begin
            errors++;
            $display("FAIL b2b_count req%0d: got %0d words done=%b want %0d words done=1",
                     r, got, finished, nexp);
         end
         full = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      req_op    = 4'h0;
      req_color = 3'b000;
      req_x0    = '0;
      req_x1    = '0;
      req_y0    = '0;
      req_y1    = '0;
      full      = 1'b0;
      test_reset();
      test_fill_basic();
      test_fill_clamp();
      test_pixel_stall();
      test_illegal_op();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
